// File: rtl/seq_stage_controller.sv
// Multi-cycle sequencer for the sequential Y86-64 core: owns PC/status,
// steps the stage units one per cycle, and selects the next PC.
module seq_stage_controller #(
  parameter logic [63:0] PC_RESET    = 64'd0,
  parameter logic [7:0]  MEM_TIMEOUT = 8'd15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  icode,
  input  logic [63:0] valC,
  input  logic [63:0] valP,
  input  logic [63:0] valM,
  input  logic        cnd,
  input  logic        imem_error,
  input  logic        instr_valid,
  input  logic        hlt,
  input  logic        dmem_ready,
  input  logic        dmem_error,
  output logic [63:0] PC,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        execute_en,
  output logic        memory_en,
  output logic        writeback_en,
  output logic [2:0]  stat,
  output logic        running,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD, S_HALTED
  } state_t;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1, STAT_HLT = 3'd2, STAT_ADR = 3'd3, STAT_INS = 3'd4
  } stat_t;

  state_t      state;
  stat_t       stat_q;
  logic [7:0]  wait_cnt;
  logic [63:0] valm_q;
  logic        is_mem;
  logic [63:0] next_pc;

  always_comb begin
    is_mem = 1'b0;
    case (icode)
      4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB: is_mem = 1'b1;
      default:                            is_mem = 1'b0;
    endcase
  end

  always_comb begin
    next_pc = valP;
    case (icode)
      4'h7:    next_pc = cnd ? valC : valP;
      4'h8:    next_pc = valC;
      4'h9:    next_pc = valm_q;
      default: next_pc = valP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      stat_q      <= STAT_AOK;
      PC          <= PC_RESET;
      instr_count <= '0;
      wait_cnt    <= '0;
      valm_q      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_FETCH;
            stat_q <= STAT_AOK;
          end
        end
        S_FETCH: begin
          if (imem_error) begin
            state  <= S_HALTED;
            stat_q <= STAT_ADR;
          end else if (!instr_valid) begin
            state  <= S_HALTED;
            stat_q <= STAT_INS;
          end else if (hlt) begin
            state  <= S_HALTED;
            stat_q <= STAT_HLT;
          end else begin
            state <= S_DECODE;
          end
        end
        S_DECODE: state <= S_EXECUTE;
        S_EXECUTE: begin
          state    <= S_MEMORY;
          wait_cnt <= '0;
        end
        S_MEMORY: begin
          // A ready response in the cycle the timeout would expire still completes.
          if (!is_mem) begin
            valm_q <= valM;
            state  <= S_WRITEBACK;
          end else if (dmem_ready) begin
            if (dmem_error) begin
              state  <= S_HALTED;
              stat_q <= STAT_ADR;
            end else begin
              valm_q <= valM;
              state  <= S_WRITEBACK;
            end
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == MEM_TIMEOUT) begin
              state  <= S_HALTED;
              stat_q <= STAT_ADR;
            end
          end
        end
        S_WRITEBACK: state <= S_PCUPD;
        S_PCUPD: begin
          PC          <= next_pc;
          instr_count <= instr_count + 32'd1;
          state       <= S_FETCH;
        end
        S_HALTED: state <= S_HALTED;
        default:  state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_en     = (state == S_FETCH);
    decode_en    = (state == S_DECODE);
    execute_en   = (state == S_EXECUTE);
    memory_en    = (state == S_MEMORY);
    writeback_en = (state == S_WRITEBACK);
    running      = (state != S_IDLE) && (state != S_HALTED);
  end

  assign stat = stat_q;

endmodule

// File: tb/tb_seq_stage_controller.sv
// Randomized bench for seq_stage_controller: a per-instruction timeline model
// queues the expected outputs for every cycle, checked at each falling edge.
module tb_seq_stage_controller;

  localparam logic [63:0] PC_RST = 64'h20;
  localparam int unsigned TMO    = 4;
  localparam logic [2:0]  AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  localparam logic [4:0]  EN_F = 5'b10000, EN_D = 5'b01000, EN_E = 5'b00100,
                          EN_M = 5'b00010, EN_W = 5'b00001, EN_0 = 5'b00000;

  logic        clk = 0, rst = 0, start = 0;
  logic [3:0]  icode = '0;
  logic [63:0] valC = '0, valP = '0, valM = '0;
  logic        cnd = 0, imem_error = 0, instr_valid = 1, hlt = 0;
  logic        dmem_ready = 0, dmem_error = 0;
  logic [63:0] PC;
  logic        fetch_en, decode_en, execute_en, memory_en, writeback_en, running;
  logic [2:0]  stat;
  logic [31:0] instr_count;

  seq_stage_controller #(.PC_RESET(PC_RST), .MEM_TIMEOUT(8'd4)) dut (
    .clk(clk), .rst(rst), .start(start), .icode(icode), .valC(valC), .valP(valP),
    .valM(valM), .cnd(cnd), .imem_error(imem_error), .instr_valid(instr_valid),
    .hlt(hlt), .dmem_ready(dmem_ready), .dmem_error(dmem_error), .PC(PC),
    .fetch_en(fetch_en), .decode_en(decode_en), .execute_en(execute_en),
    .memory_en(memory_en), .writeback_en(writeback_en), .stat(stat),
    .running(running), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  en;
    logic [63:0] pc;
    logic [2:0]  st;
    logic        run;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0, n_errors = 0;
  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  logic [31:0] m_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic is_mem_ic(input logic [3:0] ic);
    return ic inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("enables", {59'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en}, {59'd0, e.en});
      chk("pc", PC, e.pc);
      chk("stat", {61'd0, stat}, {61'd0, e.st});
      chk("running", {63'd0, running}, {63'd0, e.run});
      chk("instr_count", {32'd0, instr_count}, {32'd0, e.cnt});
    end
  end

  task automatic step(input logic [4:0] en, input logic run);
    exp_q.push_back('{en, m_pc, m_stat, run, m_count});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1; #2;
    chk("rst_pc", PC, PC_RST);
    chk("rst_stat", {61'd0, stat}, {61'd0, AOK});
    chk("rst_enables", {59'd0, fetch_en, decode_en, execute_en, memory_en, writeback_en}, 64'd0);
    chk("rst_running", {63'd0, running}, 64'd0);
    chk("rst_count", {32'd0, instr_count}, 64'd0);
    exp_q.delete();
    m_pc = PC_RST; m_stat = AOK; m_count = '0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic start_cmd();
    start = 1;
    step(EN_0, 1'b0);
    start = 0;
  endtask

  task automatic halted_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      start = 1; imem_error = $urandom; instr_valid = $urandom; hlt = $urandom;
      dmem_ready = $urandom; dmem_error = $urandom;
      step(EN_0, 1'b0);
    end
    start = 0;
  endtask

  task automatic do_instr(input logic [3:0] ic, input logic [63:0] c, input logic [63:0] p,
                          input logic [63:0] m, input logic cn, input int unsigned delay,
                          input logic derr, input logic ierr, input logic ivalid,
                          input logic h, input logic rst_in_ex);
    icode = ic; valC = c; valP = p; cnd = cn;
    imem_error = ierr; instr_valid = ivalid; hlt = h;
    start = $urandom; valM = rnd64(); dmem_ready = $urandom; dmem_error = $urandom;
    step(EN_F, 1'b1);
    if (ierr || !ivalid || h) begin
      m_stat = ierr ? ADR : (!ivalid ? INS : HLT);
      return;
    end
    imem_error = $urandom; instr_valid = $urandom; hlt = $urandom;
    step(EN_D, 1'b1);
    if (rst_in_ex) begin
      chk("mid_execute_en", {63'd0, execute_en}, 64'd1);
      do_reset();
      return;
    end
    step(EN_E, 1'b1);
    if (is_mem_ic(ic)) begin
      for (int unsigned i = 0; i < 256; i++) begin
        dmem_ready = (i >= delay);
        dmem_error = dmem_ready ? derr : 1'($urandom);
        valM = dmem_ready ? m : rnd64();
        start = $urandom;
        step(EN_M, 1'b1);
        if (dmem_ready) begin
          if (derr) begin m_stat = ADR; return; end
          break;
        end
        if (i + 1 == TMO) begin m_stat = ADR; return; end
      end
    end else begin
      valM = m; dmem_ready = $urandom; dmem_error = $urandom;
      step(EN_M, 1'b1);
    end
    valM = rnd64(); dmem_ready = $urandom; dmem_error = $urandom; start = $urandom;
    step(EN_W, 1'b1);
    step(EN_0, 1'b1);
    case (ic)
      4'h7:    m_pc = cn ? c : p;
      4'h8:    m_pc = c;
      4'h9:    m_pc = m;
      default: m_pc = p;
    endcase
    m_count = m_count + 32'd1;
  endtask

  initial begin
    #1;
    do_reset();
    start_cmd();
    do_instr(4'h3, rnd64(), 64'd10, rnd64(), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_pc_after_irmov", PC, 64'd10);
    chk("lit_count_one", {32'd0, instr_count}, 64'd1);
    chk("lit_fetch_en_back", {63'd0, fetch_en}, 64'd1);
    do_instr(4'h7, 64'h40, 64'h09, rnd64(), 1'b1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_jxx_taken", PC, 64'h40);
    do_instr(4'h7, 64'h40, 64'h09, rnd64(), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_jxx_not_taken", PC, 64'h09);
    do_instr(4'h9, rnd64(), rnd64(), 64'h100, 1'($urandom), 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("lit_ret_pc", PC, 64'h100);
    chk("lit_count_four", {32'd0, instr_count}, 64'd4);

    repeat (40) begin
      do_instr(4'($urandom_range(0, 11)), rnd64(), rnd64(), rnd64(), 1'($urandom),
               $urandom_range(0, TMO - 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    end

    do_instr(4'h2, rnd64(), rnd64(), rnd64(), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    start_cmd();
    do_instr(4'h3, rnd64(), 64'h30, rnd64(), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    do_instr(4'h6, rnd64(), rnd64(), rnd64(), 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    halted_cycles(4);
    chk("lit_imem_stat", {61'd0, stat}, {61'd0, ADR});
    chk("lit_imem_pc", PC, 64'h30);
    chk("lit_imem_running", {63'd0, running}, 64'd0);

    do_reset();
    start_cmd();
    do_instr(4'h5, rnd64(), rnd64(), rnd64(), 1'b0, 255, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    halted_cycles(3);
    chk("lit_timeout_stat", {61'd0, stat}, {61'd0, ADR});

    do_reset();
    start_cmd();
    do_instr(4'h1, rnd64(), rnd64(), rnd64(), 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    halted_cycles(2);
    chk("lit_ins_stat", {61'd0, stat}, {61'd0, INS});

    do_reset();
    start_cmd();
    do_instr(4'h0, rnd64(), rnd64(), rnd64(), 1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    halted_cycles(2);
    chk("lit_hlt_stat", {61'd0, stat}, {61'd0, HLT});

    do_reset();
    start_cmd();
    do_instr(4'h4, rnd64(), rnd64(), rnd64(), 1'b0, 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    halted_cycles(2);
    chk("lit_dmem_err_stat", {61'd0, stat}, {61'd0, ADR});
    chk("lit_dmem_err_pc", PC, PC_RST);

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
